bpu_update_ctrl: RTL

- Update and recovery controller for the global-history PHT branch predictor.
- Accepts resolved branches from the M stage into a small update FIFO and maintains the retired (committed) global history.
- Issues single-port read-modify-write updates to the PHT and signals GHR recovery on a mispredict.
- Owns the PHT write port, and runs a table-initialisation sweep after reset or an explicit table flush.

---
 rtl/bpu_pkg.sv | 49 ++++
 rtl/bpu_upd_fifo.sv | 64 ++++++
 rtl/bpu_update_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// ============================================================================
// Module   : bpu_pkg
// Purpose  : Shared types, counter encodings and helpers for the branch
//            predictor update controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bpu_pkg;

   localparam int GHR_W_DEF      = 6;
   localparam int PC_BITS_DEF    = 3;
   localparam int IDX_W_DEF      = PC_BITS_DEF + GHR_W_DEF;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef logic [1:0] ctr_t;

   // Gray-ordered so that bit[1] is the prediction and neighbours differ by one bit.
   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b11;
   localparam ctr_t CTR_ST  = 2'b10;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [IDX_W_DEF-1:0] idx;
      logic                 taken;
   } upd_entry_t;

   function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
      ctr_t nxt;
      nxt = ctr;
      case (ctr)
         CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
         default: nxt = CTR_WNT;
      endcase
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bpu_upd_fifo.sv
// ============================================================================
// Module   : bpu_upd_fifo
// Purpose  : Small synchronous FIFO holding resolved-branch update entries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpu_upd_fifo
   import bpu_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = $bits(upd_entry_t)
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign rdata   = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage carries no reset; validity is tracked purely by the count.
   always_ff @(posedge clk) begin
      if (do_push && !clr) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers are AW bits wide, so the power-of-two depth wraps them for free.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/bpu_update_ctrl.sv
// ============================================================================
// Module   : bpu_update_ctrl
// Purpose  : PHT update/recovery controller: update FIFO, retired GHR,
//            read-modify-write PHT updates and table-init sweep.
//            Optional perf counters enabled by defining BPU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpu_update_ctrl
   import bpu_pkg::*;
#(
   parameter int         GHR_W      = GHR_W_DEF,
   parameter int         PC_BITS    = PC_BITS_DEF,
   parameter int         IDX_W      = PC_BITS + GHR_W,
   parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter logic [1:0] INIT_CTR   = CTR_WNT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_tbl_i,
   input  logic              branchM,
   input  logic [31:0]       pcM,
   input  logic              actual_takeM,
   input  logic              pred_takeM,
   output logic              stall_req_o,
   output logic              ghr_restore_o,
   output logic [GHR_W-1:0]  ghr_restore_val_o,
   output logic [GHR_W-1:0]  retired_ghr_o,
   output logic [IDX_W-1:0]  pht_ridx_o,
   input  logic [1:0]        pht_rdata_i,
   output logic              pht_we_o,
   output logic [IDX_W-1:0]  pht_widx_o,
   output logic [1:0]        pht_wdata_o,
   output logic              init_busy_o
`ifdef BPU_PERF_CNT_EN
   ,
   output logic [31:0]       br_cnt_o,
   output logic [31:0]       mispred_cnt_o
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = IDX_W + 1;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] sweep_idx;
   logic [GHR_W-1:0] retired_ghr;
   logic             clear;
   logic             push;
   logic             pop;
   logic             sweep_last;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [ENT_W-1:0] push_ent;
   logic [ENT_W-1:0] head_ent;
   logic [IDX_W-1:0] head_idx;
   logic             head_taken;
   logic             unused_pc;

   assign clear      = rst | flush_tbl_i;
   assign push       = branchM & ~fifo_full & ~clear;
   assign pop        = (state == ST_RUN) & ~fifo_empty;
   assign push_ent   = {pcM[PC_BITS+1:2], retired_ghr, actual_takeM};
   assign head_idx   = head_ent[ENT_W-1:1];
   assign head_taken = head_ent[0];
   assign sweep_last = &sweep_idx;
   assign unused_pc  = ^{pcM[31:PC_BITS+2], pcM[1:0]};

   assign stall_req_o       = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign ghr_restore_o     = push & (pred_takeM ^ actual_takeM);
   assign ghr_restore_val_o = {retired_ghr[GHR_W-2:0], actual_takeM};
   assign retired_ghr_o     = retired_ghr;
   assign init_busy_o       = (state == ST_INIT);

   bpu_upd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .clr   (clear),
      .push  (push),
      .wdata (push_ent),
      .pop   (pop),
      .rdata (head_ent),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         state       <= ST_INIT;
         sweep_idx   <= '0;
         retired_ghr <= '0;
      end else begin
         state <= state_next;
         if (state == ST_INIT) sweep_idx <= sweep_idx + 1'b1;
         if (push) retired_ghr <= {retired_ghr[GHR_W-2:0], actual_takeM};
      end
   end

   // The table read is combinational, so the write lands before the next read
   // and back-to-back updates to one index chain correctly.
   always_comb begin
      state_next  = state;
      pht_we_o    = 1'b0;
      pht_widx_o  = '0;
      pht_wdata_o = CTR_SNT;
      pht_ridx_o  = fifo_empty ? '0 : head_idx;
      case (state)
         ST_INIT: begin
            pht_we_o    = 1'b1;
            pht_widx_o  = sweep_idx;
            pht_wdata_o = INIT_CTR;
            if (sweep_last) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (pop) begin
               pht_we_o    = 1'b1;
               pht_widx_o  = head_idx;
               pht_wdata_o = ctr_next(pht_rdata_i, head_taken);
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

`ifdef BPU_PERF_CNT_EN
   // Cleared by rst only so that statistics survive a table flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_o      <= '0;
         mispred_cnt_o <= '0;
      end else begin
         if (push)          br_cnt_o      <= br_cnt_o + 32'd1;
         if (ghr_restore_o) mispred_cnt_o <= mispred_cnt_o + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire
